// File: rtl/wb_exc_commit.sv
// WB-stage commit unit: retires MEM instructions, drives the CSR port and WB2CSR bus, raises flush/redirect.
// Optional WB_EXC_STATS_EN adds exc_cnt/ertn_cnt event counters.
module wb_exc_commit #(
    parameter int unsigned CSR_BUS_W = 49,
    parameter logic [5:0]  ECODE_INT = 6'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ms_valid,
    output logic                 ws_allowin,
    input  logic [31:0]          ms_pc,
    input  logic                 ms_ex,
    input  logic [5:0]           ms_ecode,
    input  logic [8:0]           ms_esubcode,
    input  logic                 ms_ertn,
    input  logic                 ms_csr_re,
    input  logic                 ms_csr_we,
    input  logic [13:0]          ms_csr_num,
    input  logic [31:0]          ms_csr_wmask,
    input  logic [31:0]          ms_csr_wvalue,
    input  logic                 ms_rf_we,
    input  logic [4:0]           ms_rf_waddr,
    input  logic [31:0]          ms_rf_wdata,
    input  logic                 has_int,
    input  logic [31:0]          ex_entry,
    input  logic [31:0]          ertn_entry,
    input  logic [31:0]          csr_rvalue,
    output logic                 csr_re,
    output logic [13:0]          csr_num,
    output logic                 csr_we,
    output logic [31:0]          csr_wmask,
    output logic [31:0]          csr_wvalue,
    output logic [CSR_BUS_W-1:0] csr_in_bus,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic                 flush,
    output logic [31:0]          flush_pc,
`ifdef WB_EXC_STATS_EN
    output logic [31:0]          exc_cnt,
    output logic [31:0]          ertn_cnt,
`endif
    input  logic                 fs_redirect_rdy
);

    typedef enum logic [0:0] {StRun, StRedir} state_e;

    state_e      state_q;
    logic        ws_valid_q;
    logic [31:0] ws_pc_q;
    logic        ws_ex_q;
    logic [5:0]  ws_ecode_q;
    logic [8:0]  ws_esubcode_q;
    logic        ws_ertn_q;
    logic        ws_csr_re_q;
    logic        ws_csr_we_q;
    logic [13:0] ws_csr_num_q;
    logic [31:0] ws_csr_wmask_q;
    logic [31:0] ws_csr_wvalue_q;
    logic        ws_rf_we_q;
    logic [4:0]  ws_rf_waddr_q;
    logic [31:0] ws_rf_wdata_q;
    logic [31:0] flush_pc_q;

    logic take_int, take_ex, take_ertn, take_norm, commit_flush;
    logic       wb_ex, ertn_flush;
    logic [5:0] wb_ecode;
    logic [8:0] wb_esubcode;
    logic [31:0] wb_pc;

    always_comb begin
        take_int     = ws_valid_q && has_int;
        take_ex      = ws_valid_q && !has_int && ws_ex_q;
        take_ertn    = ws_valid_q && !has_int && !ws_ex_q && ws_ertn_q;
        take_norm    = ws_valid_q && !take_int && !take_ex && !take_ertn;
        commit_flush = take_int || take_ex || take_ertn;
    end

    always_comb begin
        wb_ex       = take_int || take_ex;
        ertn_flush  = take_ertn;
        wb_ecode    = take_int ? ECODE_INT : (take_ex ? ws_ecode_q : 6'h00);
        wb_esubcode = take_ex ? ws_esubcode_q : 9'h000;
        wb_pc       = ws_valid_q ? ws_pc_q : 32'h0;
        csr_in_bus  = {ertn_flush, wb_ex, wb_ecode, wb_esubcode, wb_pc};

        // The read sees the pre-write value; the write lands at the next edge.
        csr_re     = ws_valid_q && ws_csr_re_q;
        csr_num    = ws_valid_q ? ws_csr_num_q : 14'h0;
        csr_we     = take_norm && ws_csr_we_q;
        csr_wmask  = ws_valid_q ? ws_csr_wmask_q : 32'h0;
        csr_wvalue = ws_valid_q ? ws_csr_wvalue_q : 32'h0;

        rf_we    = take_norm && ws_rf_we_q;
        rf_waddr = ws_valid_q ? ws_rf_waddr_q : 5'h0;
        rf_wdata = !ws_valid_q ? 32'h0 : (ws_csr_re_q ? csr_rvalue : ws_rf_wdata_q);

        ws_allowin = 1'b1;
        flush      = (state_q == StRedir);
        flush_pc   = flush_pc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StRun;
            ws_valid_q      <= 1'b0;
            flush_pc_q      <= 32'h0;
            ws_pc_q         <= 32'h0;
            ws_ex_q         <= 1'b0;
            ws_ecode_q      <= 6'h0;
            ws_esubcode_q   <= 9'h0;
            ws_ertn_q       <= 1'b0;
            ws_csr_re_q     <= 1'b0;
            ws_csr_we_q     <= 1'b0;
            ws_csr_num_q    <= 14'h0;
            ws_csr_wmask_q  <= 32'h0;
            ws_csr_wvalue_q <= 32'h0;
            ws_rf_we_q      <= 1'b0;
            ws_rf_waddr_q   <= 5'h0;
            ws_rf_wdata_q   <= 32'h0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (commit_flush) begin
                        state_q    <= StRedir;
                        flush_pc_q <= take_ertn ? ertn_entry : ex_entry;
                    end
                    // A younger instruction arriving alongside a flushing commit is killed.
                    ws_valid_q <= ms_valid && ws_allowin && !commit_flush;
                    if (ms_valid && ws_allowin) begin
                        ws_pc_q         <= ms_pc;
                        ws_ex_q         <= ms_ex;
                        ws_ecode_q      <= ms_ecode;
                        ws_esubcode_q   <= ms_esubcode;
                        ws_ertn_q       <= ms_ertn;
                        ws_csr_re_q     <= ms_csr_re;
                        ws_csr_we_q     <= ms_csr_we;
                        ws_csr_num_q    <= ms_csr_num;
                        ws_csr_wmask_q  <= ms_csr_wmask;
                        ws_csr_wvalue_q <= ms_csr_wvalue;
                        ws_rf_we_q      <= ms_rf_we;
                        ws_rf_waddr_q   <= ms_rf_waddr;
                        ws_rf_wdata_q   <= ms_rf_wdata;
                    end
                end
                StRedir: begin
                    ws_valid_q <= 1'b0;
                    if (fs_redirect_rdy) state_q <= StRun;
                end
                default: state_q <= StRun;
            endcase
        end
    end

`ifdef WB_EXC_STATS_EN
    logic [31:0] exc_cnt_q, ertn_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_cnt_q  <= 32'h0;
            ertn_cnt_q <= 32'h0;
        end else begin
            if (wb_ex)      exc_cnt_q  <= exc_cnt_q + 32'h1;
            if (ertn_flush) ertn_cnt_q <= ertn_cnt_q + 32'h1;
        end
    end

    always_comb begin
        exc_cnt  = exc_cnt_q;
        ertn_cnt = ertn_cnt_q;
    end
`endif

endmodule

// File: tb/tb_wb_exc_commit.sv
// Randomized and directed bench for wb_exc_commit against a transaction-level reference model.
module tb_wb_exc_commit;

    localparam logic [5:0] ECODE_INT = 6'h00;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ms_valid, ws_allowin;
    logic [31:0] ms_pc;
    logic        ms_ex;
    logic [5:0]  ms_ecode;
    logic [8:0]  ms_esubcode;
    logic        ms_ertn, ms_csr_re, ms_csr_we;
    logic [13:0] ms_csr_num;
    logic [31:0] ms_csr_wmask, ms_csr_wvalue;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [31:0] ms_rf_wdata;
    logic        has_int;
    logic [31:0] ex_entry, ertn_entry, csr_rvalue;
    logic        csr_re, csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask, csr_wvalue;
    logic [48:0] csr_in_bus;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fs_redirect_rdy;
`ifdef WB_EXC_STATS_EN
    logic [31:0] exc_cnt, ertn_cnt;
`endif

    wb_exc_commit #(.CSR_BUS_W(49), .ECODE_INT(ECODE_INT)) dut (
        .clk(clk), .reset(reset), .ms_valid(ms_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode),
        .ms_ertn(ms_ertn), .ms_csr_re(ms_csr_re), .ms_csr_we(ms_csr_we),
        .ms_csr_num(ms_csr_num), .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue),
        .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
        .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
        .csr_rvalue(csr_rvalue), .csr_re(csr_re), .csr_num(csr_num), .csr_we(csr_we),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_in_bus(csr_in_bus),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flush(flush),
        .flush_pc(flush_pc),
`ifdef WB_EXC_STATS_EN
        .exc_cnt(exc_cnt), .ertn_cnt(ertn_cnt),
`endif
        .fs_redirect_rdy(fs_redirect_rdy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the retiring instruction, whether a redirect is pending, and event counts.
    typedef struct packed {
        logic [31:0] pc;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic        ertn;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] num;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } instr_t;

    instr_t      m_ins;
    bit          m_valid, m_redir;
    logic [31:0] m_target;
    logic [31:0] m_exc, m_ertn;

    task automatic set_idle();
        ms_valid = 0; ms_pc = 0; ms_ex = 0; ms_ecode = 0; ms_esubcode = 0; ms_ertn = 0;
        ms_csr_re = 0; ms_csr_we = 0; ms_csr_num = 0; ms_csr_wmask = 0; ms_csr_wvalue = 0;
        ms_rf_we = 0; ms_rf_waddr = 0; ms_rf_wdata = 0; has_int = 0;
        fs_redirect_rdy = 0; csr_rvalue = 0;
    endtask

    // Check this cycle's outputs against the model, then advance one clock.
    task automatic step();
        bit is_int, is_ex, is_ertn, is_norm;
        logic [5:0] e_ecode;
        #1;
        is_int  = m_valid && has_int;
        is_ex   = m_valid && !has_int && m_ins.ex;
        is_ertn = m_valid && !has_int && !m_ins.ex && m_ins.ertn;
        is_norm = m_valid && !is_int && !is_ex && !is_ertn;
        e_ecode = is_int ? ECODE_INT : m_ins.ecode;

        check_val("ws_allowin", ws_allowin, 1);
        check_val("ertn_flush", csr_in_bus[48], is_ertn);
        check_val("wb_ex", csr_in_bus[47], is_int || is_ex);
        if (is_int || is_ex) begin
            check_val("wb_ecode", csr_in_bus[46:41], e_ecode);
            check_val("wb_esubcode", csr_in_bus[40:32], is_ex ? m_ins.esub : 9'h0);
            check_val("wb_pc", csr_in_bus[31:0], m_ins.pc);
        end
        check_val("csr_we", csr_we, is_norm && m_ins.csr_we);
        check_val("csr_re", csr_re, m_valid && m_ins.csr_re);
        if (m_valid) check_val("csr_num", csr_num, m_ins.num);
        if (is_norm && m_ins.csr_we) begin
            check_val("csr_wmask", csr_wmask, m_ins.wmask);
            check_val("csr_wvalue", csr_wvalue, m_ins.wvalue);
        end
        check_val("rf_we", rf_we, is_norm && m_ins.rf_we);
        if (is_norm && m_ins.rf_we) begin
            check_val("rf_waddr", rf_waddr, m_ins.waddr);
            check_val("rf_wdata", rf_wdata, m_ins.csr_re ? csr_rvalue : m_ins.wdata);
        end
        check_val("flush", flush, m_redir);
        if (m_redir) check_val("flush_pc", flush_pc, m_target);
`ifdef WB_EXC_STATS_EN
        check_val("exc_cnt", exc_cnt, m_exc);
        check_val("ertn_cnt", ertn_cnt, m_ertn);
`endif

        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_redir = 0; m_exc = 0; m_ertn = 0;
        end else begin
            if (is_int || is_ex) m_exc = m_exc + 1;
            if (is_ertn) m_ertn = m_ertn + 1;
            if (m_redir) begin
                if (fs_redirect_rdy) m_redir = 0;
                m_valid = 0;
            end else begin
                if (is_int || is_ex || is_ertn) begin
                    m_redir  = 1;
                    m_target = is_ertn ? ertn_entry : ex_entry;
                end
                m_valid = ms_valid && !(is_int || is_ex || is_ertn);
                m_ins = '{pc: ms_pc, ex: ms_ex, ecode: ms_ecode, esub: ms_esubcode,
                          ertn: ms_ertn, csr_re: ms_csr_re, csr_we: ms_csr_we, num: ms_csr_num,
                          wmask: ms_csr_wmask, wvalue: ms_csr_wvalue, rf_we: ms_rf_we,
                          waddr: ms_rf_waddr, wdata: ms_rf_wdata};
            end
        end
        @(negedge clk);
    endtask

    task automatic send_csrwr(input logic [13:0] num, input logic [31:0] val);
        ms_valid = 1; ms_pc = 32'h1c000004; ms_csr_re = 1; ms_csr_we = 1; ms_csr_num = num;
        ms_csr_wmask = 32'hFFFFFFFF; ms_csr_wvalue = val; ms_rf_we = 1; ms_rf_waddr = 5'd4;
    endtask

    task automatic send_ex(input logic [31:0] pc, input logic [5:0] ecode);
        ms_valid = 1; ms_pc = pc; ms_ex = 1; ms_ecode = ecode; ms_rf_we = 1; ms_rf_waddr = 5'd7;
    endtask

    initial begin
        m_ins = '0; m_valid = 0; m_redir = 0; m_target = 0; m_exc = 0; m_ertn = 0;
        set_idle();
        ex_entry = 32'h1c008000; ertn_entry = 32'h1c000014;
        reset = 1;
        @(posedge clk); @(negedge clk);
        step();
        reset = 0;
        check_val("flush_pc_reset", flush_pc, 0);
        step();

        // ALU retire
        ms_valid = 1; ms_pc = 32'h1c000000; ms_rf_we = 1; ms_rf_waddr = 5; ms_rf_wdata = 32'h1234;
        step();
        set_idle();
        step();

        // csrwr returns the old CSR value
        send_csrwr(14'h30, 32'hA5A5A5A5);
        step();
        set_idle(); csr_rvalue = 32'h11;
        step();

        // SYS exception, redirect held three cycles
        send_ex(32'h1c000010, 6'h0B);
        step();
        set_idle();
        step();
        repeat (3) step();
        fs_redirect_rdy = 1;
        step();
        fs_redirect_rdy = 0;
        step();

        // ertn, with instructions offered during the redirect
        ms_valid = 1; ms_pc = 32'h1c000020; ms_ertn = 1;
        step();
        set_idle();
        step();
        ms_valid = 1; ms_rf_we = 1; ms_rf_waddr = 9; ms_rf_wdata = 32'hDEAD;
        repeat (2) step();
        set_idle(); fs_redirect_rdy = 1;
        step();
        fs_redirect_rdy = 0;
        repeat (2) step();

        // interrupt over csrwr, then interrupt over an exception
        send_csrwr(14'h30, 32'h5);
        step();
        set_idle(); has_int = 1;
        step();
        set_idle(); fs_redirect_rdy = 1;
        step();
        set_idle();
        send_ex(32'h1c000030, 6'h0B); ms_esubcode = 9'h1;
        step();
        set_idle(); has_int = 1;
        step();
        set_idle();
        step();

        // reset while redirecting
        reset = 1;
        step();
        reset = 0;
        step();
        step();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            ms_valid        = ($urandom_range(0, 99) < 60);
            ms_pc           = $urandom;
            ms_ex           = ($urandom_range(0, 99) < 6);
            ms_ecode        = 6'($urandom);
            ms_esubcode     = 9'($urandom);
            ms_ertn         = ($urandom_range(0, 99) < 5);
            ms_csr_re       = 1'($urandom);
            ms_csr_we       = 1'($urandom);
            ms_csr_num      = 14'($urandom);
            ms_csr_wmask    = $urandom;
            ms_csr_wvalue   = $urandom;
            ms_rf_we        = 1'($urandom);
            ms_rf_waddr     = 5'($urandom);
            ms_rf_wdata     = $urandom;
            has_int         = ($urandom_range(0, 99) < 4);
            fs_redirect_rdy = ($urandom_range(0, 99) < 35);
            csr_rvalue      = $urandom;
            ex_entry        = $urandom;
            ertn_entry      = $urandom;
            reset           = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 0;
        set_idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
